// File: rtl/pb_debouncer_if.sv
//------------------------------------------------------------------------------
// Module : pb_debouncer_if
// Brief  : Button-side signal bundle between a raw pad and its debouncer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pb_debouncer_if;
    logic PB;
    logic PB_pressed_status;
    logic PB_pressed_pulse;
    logic PB_released_pulse;

    // master drives the pad and consumes the conditioned outputs
    modport master (
        output PB,
        input  PB_pressed_status,
        input  PB_pressed_pulse,
        input  PB_released_pulse
    );

    modport slave (
        input  PB,
        output PB_pressed_status,
        output PB_pressed_pulse,
        output PB_released_pulse
    );
endinterface

`default_nettype wire

// File: rtl/pb_debouncer.sv
//------------------------------------------------------------------------------
// Module : pb_debouncer
// Brief  : Synchronizes a raw push-button and filters bounce into a clean level
//          plus single-cycle press/release pulses.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pb_debouncer #(
    parameter int DELAY       = 500_000,
    parameter int DELAY_WIDTH = $clog2(DELAY),
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pb_debouncer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } state_t;

    localparam logic [DELAY_WIDTH-1:0] c_count_max = DELAY_WIDTH'(DELAY - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_pb_sync;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DELAY_WIDTH-1:0] r_count;
    logic [DELAY_WIDTH-1:0] w_count_next;

    logic                   r_status;
    logic                   r_press_pulse;
    logic                   r_release_pulse;
    logic                   w_status_next;
    logic                   w_press_next;
    logic                   w_release_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.PB};
        end
    end

    assign w_pb_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_count         <= '0;
            r_status        <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_count         <= w_count_next;
            r_status        <= w_status_next;
            r_press_pulse   <= w_press_next;
            r_release_pulse <= w_release_next;
        end
    end

    // Outputs are derived from the next state so they register on the same
    // edge as the accepting transition.
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = '0;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_pb_sync) begin
                    w_state_next = PRESS_CHECK;
                end
            end
            PRESS_CHECK: begin
                if (!w_pb_sync) begin
                    w_state_next = IDLE;
                end else if (r_count == c_count_max) begin
                    w_state_next = PRESSED;
                    w_press_next = 1'b1;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_pb_sync) begin
                    w_state_next = RELEASE_CHECK;
                end
            end
            RELEASE_CHECK: begin
                if (w_pb_sync) begin
                    w_state_next = PRESSED;
                end else if (r_count == c_count_max) begin
                    w_state_next   = IDLE;
                    w_release_next = 1'b1;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_status_next = (w_state_next == PRESSED) || (w_state_next == RELEASE_CHECK);
    end

    assign bus.PB_pressed_status = r_status;
    assign bus.PB_pressed_pulse  = r_press_pulse;
    assign bus.PB_released_pulse = r_release_pulse;

endmodule

`default_nettype wire

// File: tb/tb_pb_debouncer.sv
//------------------------------------------------------------------------------
// Module : tb_pb_debouncer
// Brief  : Self-checking bench for pb_debouncer against a run-length model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pb_debouncer;

    localparam int DELAY = 4;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pb_debouncer_if bus ();

    pb_debouncer #(
        .DELAY       (DELAY),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the accepted level flips once the synchronized input has
    // disagreed with it on DELAY+1 consecutive sampling edges.
    bit hist [SYNC];
    int run;
    bit lvl, m_press, m_rel;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
            run = 0; lvl = 1'b0; m_press = 1'b0; m_rel = 1'b0;
        end else begin
            bit s;
            s = hist[SYNC-1];
            for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.PB;
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (s != lvl) begin
                run++;
                if (run == DELAY + 1) begin
                    lvl = s; run = 0;
                    m_press = s; m_rel = !s;
                end
            end else begin
                run = 0;
            end
        end
    end

    bit cmp_en = 1'b0;
    int n_press = 0, n_rel = 0;
    bit last_press = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("status", bus.PB_pressed_status, lvl);
            check("press_pulse", bus.PB_pressed_pulse, m_press);
            check("release_pulse", bus.PB_released_pulse, m_rel);
            if (bus.PB_pressed_pulse && bus.PB_released_pulse)
                check("pulse_overlap", 1, 0);
            if (bus.PB_pressed_pulse === 1'b1) begin
                n_press++;
                if (last_press) check("alternate_press", 1, 0);
                last_press = 1'b1;
            end
            if (bus.PB_released_pulse === 1'b1) begin
                n_rel++;
                if (!last_press) check("alternate_release", 1, 0);
                last_press = 1'b0;
            end
            if (rst) last_press = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0, r0;
        bit v;
        bus.PB = 1'b1;

        // reset with the button held, then full-latency detection
        rst = 1'b1;
        step(3);
        cmp_en = 1'b1;
        check("rst_status", bus.PB_pressed_status, 0);
        check("rst_press", bus.PB_pressed_pulse, 0);
        check("rst_release", bus.PB_released_pulse, 0);
        rst = 1'b0;
        step(6);
        check("lat_status_e6", bus.PB_pressed_status, 0);
        step(1);
        check("lat_press_e7", bus.PB_pressed_pulse, 1);
        check("lat_status_e7", bus.PB_pressed_status, 1);
        check("model_press_e7", m_press, 1);
        step(1);
        check("lat_press_e8", bus.PB_pressed_pulse, 0);
        check("lat_status_e8", bus.PB_pressed_status, 1);
        step(12);

        // clean release
        bus.PB = 1'b0;
        step(6);
        check("rel_status_e6", bus.PB_pressed_status, 1);
        step(1);
        check("rel_pulse_e7", bus.PB_released_pulse, 1);
        check("rel_status_e7", bus.PB_pressed_status, 0);
        check("model_rel_e7", m_rel, 1);
        step(1);
        check("rel_pulse_e8", bus.PB_released_pulse, 0);
        step(5);

        // press bounce: high 3, low 1, high 2, low
        p0 = n_press; r0 = n_rel;
        bus.PB = 1'b1; step(3);
        bus.PB = 1'b0; step(1);
        bus.PB = 1'b1; step(2);
        bus.PB = 1'b0; step(10);
        check("bounce_no_press", n_press - p0, 0);
        check("bounce_status", bus.PB_pressed_status, 0);
        check("bounce_idle_count", dut.r_count, 0);

        // release bounce: low 2, high 1, low held
        bus.PB = 1'b1; step(10);
        p0 = n_press; r0 = n_rel;
        bus.PB = 1'b0; step(2);
        bus.PB = 1'b1; step(1);
        bus.PB = 1'b0;
        step(6);
        check("rbounce_status_e6", bus.PB_pressed_status, 1);
        check("rbounce_no_rel_yet", n_rel - r0, 0);
        step(1);
        check("rbounce_rel_e7", bus.PB_released_pulse, 1);
        step(5);
        check("rbounce_one_rel", n_rel - r0, 1);

        // reset mid PRESS_CHECK (count=2)
        bus.PB = 1'b1; step(5);
        check("midcheck_count", dut.r_count, 2);
        rst = 1'b1; step(1);
        check("midcheck_rst_count", dut.r_count, 0);
        check("midcheck_rst_status", bus.PB_pressed_status, 0);
        rst = 1'b0; bus.PB = 1'b0; step(5);

        // reset while PRESSED; re-detect with PB still held
        bus.PB = 1'b1; step(9);
        check("pressed_status", bus.PB_pressed_status, 1);
        r0 = n_rel;
        rst = 1'b1; step(1);
        check("pressed_rst_status", bus.PB_pressed_status, 0);
        rst = 1'b0;
        step(6);
        check("redetect_e6", bus.PB_pressed_status, 0);
        step(1);
        check("redetect_e7", bus.PB_pressed_pulse, 1);
        check("pressed_rst_no_rel", n_rel - r0, 0);
        bus.PB = 1'b0; step(10);

        // repetition
        p0 = n_press; r0 = n_rel;
        for (int k = 0; k < 5; k++) begin
            bus.PB = 1'b1; step(10);
            bus.PB = 1'b0; step(10);
        end
        check("rep_press_count", n_press - p0, 5);
        check("rep_rel_count", n_rel - r0, 5);

        // randomized bouncing segments with occasional reset
        v = 1'b0;
        for (int seg = 0; seg < 400; seg++) begin
            v = !v;
            bus.PB = v;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0;
            end
            step($urandom_range(1, 12));
        end
        bus.PB = 1'b0;
        step(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
